// File: rtl/updown_count_ctrl.sv
// Bounded up/down count sequencer with start/stop/hold control, one-shot or repeat runs.
// Optional ping-pong mode is compiled in when PINGPONG_EN is defined.
module updown_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             tick,
  input  logic             dir_in,
  input  logic             repeat_in,
  input  logic             pingpong,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Count,
  output logic             UpDown,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             updown_q, updown_d;
  logic             rpt_q, rpt_d;
  logic             pp_q, pp_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             at_end;
  logic             pp_start;

`ifdef PINGPONG_EN
  assign pp_start = pingpong;
`else
  logic unused_pingpong;
  assign unused_pingpong = pingpong;
  assign pp_start = 1'b0;
`endif

  // End bound follows the current direction so ping-pong reversal needs no extra state.
  assign at_end = updown_q ? (count_q == limit_q)
                           : (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    updown_d = updown_q;
    rpt_d    = rpt_q;
    pp_d     = pp_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d  = RUN;
          count_d  = dir_in ? '0 : limit;
          updown_d = dir_in;
          limit_d  = limit;
          rpt_d    = repeat_in;
          pp_d     = pp_start;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (hold) begin
          state_d = HOLD;
        end else if (tick) begin
          if (!at_end) begin
            count_d = updown_q ? count_q + 1'b1
                               : count_q - 1'b1;
          end else if (pp_q) begin
            updown_d = ~updown_q;
            wrap_d   = 1'b1;
            if (limit_q != '0) begin
              count_d = updown_q ? count_q - 1'b1
                                 : count_q + 1'b1;
            end
          end else if (rpt_q) begin
            count_d = updown_q ? '0 : limit_q;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      updown_q <= 1'b1;
      rpt_q    <= 1'b0;
      pp_q     <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      updown_q <= updown_d;
      rpt_q    <= rpt_d;
      pp_q     <= pp_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Count  = count_q;
  assign UpDown = updown_q;
  assign busy   = (state_q == RUN) || (state_q == HOLD);
  assign done   = done_q;
  assign wrap   = wrap_q;
  assign state  = state_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Randomized and directed bench for updown_count_ctrl against a behavioural model.
// Define PINGPONG_EN for both bench and RTL to exercise ping-pong runs.
module tb_updown_count_ctrl;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 0, stop = 0, hold = 0, tick = 0;
  logic         dir_in = 1, repeat_in = 0, pingpong = 0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] Count;
  logic         UpDown, busy, done, wrap;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: states as plain integers 0=idle 1=run 2=hold 3=done
  int m_st, m_cnt, m_up, m_lim, m_rpt, m_pp, m_done, m_wrap;

  updown_count_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .stop(stop),
    .hold(hold), .tick(tick), .dir_in(dir_in),
    .repeat_in(repeat_in), .pingpong(pingpong), .limit(limit),
    .Count(Count), .UpDown(UpDown), .busy(busy), .done(done),
    .wrap(wrap), .state(state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_up = 1; m_lim = 0;
    m_rpt = 0; m_pp = 0; m_done = 0; m_wrap = 0;
  endfunction

  function automatic void model_step();
    int endv;
    m_done = 0;
    m_wrap = 0;
    if (stop) begin
      m_st = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_st  = 1;
        m_up  = dir_in;
        m_lim = limit;
        m_cnt = dir_in ? 0 : int'(limit);
        m_rpt = repeat_in;
`ifdef PINGPONG_EN
        m_pp  = pingpong;
`else
        m_pp  = 0;
`endif
      end
    end else if (m_st == 2) begin
      if (!hold) m_st = 1;
    end else if (hold) begin
      m_st = 2;
    end else if (tick) begin
      endv = m_up ? m_lim : 0;
      if (m_cnt != endv) begin
        m_cnt = m_cnt + (m_up ? 1 : -1);
      end else if (m_pp) begin
        m_up   = !m_up;
        m_wrap = 1;
        if (m_lim != 0) m_cnt = m_cnt + (m_up ? 1 : -1);
      end else if (m_rpt) begin
        m_cnt  = m_up ? 0 : m_lim;
        m_wrap = 1;
      end else begin
        m_st   = 3;
        m_done = 1;
      end
    end
  endfunction

  task automatic check_all();
    chk("count",  int'(Count),  m_cnt);
    chk("updown", int'(UpDown), m_up);
    chk("state",  int'(state),  m_st);
    chk("busy",   int'(busy),   int'(m_st == 1 || m_st == 2));
    chk("done",   int'(done),   m_done);
    chk("wrap",   int'(wrap),   m_wrap);
  endtask

  task automatic cyc(input logic st, input logic sp, input logic hd,
                     input logic tk, input logic dr, input logic rp,
                     input logic pp, input int lim);
    start = st; stop = sp; hold = hd; tick = tk;
    dir_in = dr; repeat_in = rp; pingpong = pp;
    limit = W'(lim);
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    chk("rst_upd", int'(UpDown), 1);
    reset = 1'b0;
    @(negedge Clk);
    check_all();

    // async reset mid-run at Count=5
    cyc(1, 0, 0, 1, 1, 0, 0, 9);
    ticks(5);
    chk("t1_cnt5", int'(Count), 5);
    #2 reset = 1'b1;
    #1;
    chk("t1_cnt", int'(Count), 0);
    chk("t1_upd", int'(UpDown), 1);
    chk("t1_st", int'(state), 0);
    chk("t1_busy", int'(busy), 0);
    model_reset();
    @(negedge Clk);
    reset = 1'b0;
    check_all();

    // up one-shot to 9
    cyc(1, 0, 0, 1, 1, 0, 0, 9);
    chk("t2_s", int'(Count), 0);
    ticks(9);
    chk("t2_9", int'(Count), 9);
    chk("t2_nd", int'(done), 0);
    ticks(1);
    chk("t2_done", int'(done), 1);
    chk("t2_st", int'(state), 3);
    chk("t2_cnt", int'(Count), 9);
    ticks(1);
    chk("t2_pulse", int'(done), 0);

    // down repeat from 6
    cyc(1, 0, 0, 1, 0, 1, 0, 6);
    chk("t3_s", int'(Count), 6);
    ticks(6);
    chk("t3_0", int'(Count), 0);
    chk("t3_nw", int'(wrap), 0);
    ticks(1);
    chk("t3_wrap", int'(wrap), 1);
    chk("t3_cnt", int'(Count), 6);
    ticks(1);
    chk("t3_5", int'(Count), 5);
    chk("t3_pulse", int'(wrap), 0);

    // hold at 3
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 9);
    ticks(3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0, 0, 0);
    chk("t4_cnt", int'(Count), 3);
    chk("t4_st", int'(state), 2);
    ticks(2);
    chk("t4_res", int'(Count), 4);

    // start with stop, start while running
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 0, 0, 9);
    chk("t5_idle", int'(state), 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 9);
    ticks(2);
    cyc(1, 0, 0, 1, 0, 1, 0, 3);
    chk("t5_cnt", int'(Count), 3);
    chk("t5_upd", int'(UpDown), 1);

    // limit=0 one-shot and repeat
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0);
    ticks(1);
    chk("l0_done", int'(done), 1);
    cyc(1, 0, 0, 1, 0, 1, 0, 0);
    ticks(1);
    chk("l0_wrap", int'(wrap), 1);
    chk("l0_cnt", int'(Count), 0);

`ifdef PINGPONG_EN
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 3);
    ticks(3);
    ticks(1);
    chk("t6_rev", int'(Count), 2);
    chk("t6_wrap", int'(wrap), 1);
    chk("t6_upd", int'(UpDown), 0);
    ticks(2);
    ticks(1);
    chk("t6_rev0", int'(Count), 1);
    chk("t6_upd0", int'(UpDown), 1);
`endif

    // random soak
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("rnd_rst", int'(Count), 0);
        @(negedge Clk);
        reset = 1'b0;
        check_all();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
